// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the handshaked RV32I data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    byte_mask = 4'b0001 << off;
      SZ_H:    byte_mask = off[1] ? 4'b1100 : 4'b0011;
      SZ_W:    byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rword, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = rword[{off, 3'b000} +: 8];
    h = off[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_B:    load_extend = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    load_extend = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extend = rword;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte mask, replicated store word, extended load data, misalign flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  mask,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  always_comb begin
    mask  = byte_mask(size, off);
    rdata = load_extend(rword, size, off, uns);
    case (size)
      SZ_B:    wword = {4{wdata[7:0]}};
      SZ_H:    wword = {2{wdata[15:0]}};
      default: wword = wdata;
    endcase
    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = off[0];
      SZ_W:    misalign = (off != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data memory: one load/store in flight, optional wait states, registered response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_next;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic          oob;
  logic          misalign;
  logic          err;
  logic          wr_en;
  logic [3:0]    mask;
  logic [31:0]   wword;
  logic [31:0]   rword;
  logic [31:0]   rdata_al;

  assign idx   = addr_q[AW+1:2];
  assign oob   = |addr_q[31:AW+2];
  assign rword = mem[idx];
  assign err   = misalign | oob;
  // Reset in the ACCESS cycle must suppress the store, so it gates the write directly.
  assign wr_en = (state == ST_ACCESS) && we_q && !err && !reset;

  dmem_lane_align u_align (
    .size     (size_q),
    .off      (addr_q[1:0]),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .rword    (rword),
    .mask     (mask),
    .wword    (wword),
    .rdata    (rdata_al),
    .misalign (misalign)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (cnt_q == 4'd0) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   if (resp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt_q   <= WAIT_INIT;
      end
      if (state == ST_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (state == ST_ACCESS) begin
        err_q   <= err;
        rdata_q <= (err || we_q) ? '0 : rdata_al;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench: a zero-wait and a three-wait-state instance share stimulus.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic        v0, v1, rr0, rr1;
  logic        rdy0, rdy1, rv0, rv1, er0, er1;
  logic [31:0] rd0, rd1;

  int          sel;
  logic        rdy, rv, er;
  logic [31:0] rd;

  always_comb begin
    rdy = (sel != 0) ? rdy1 : rdy0;
    rv  = (sel != 0) ? rv1  : rv0;
    er  = (sel != 0) ? er1  : er0;
    rd  = (sel != 0) ? rd1  : rd0;
  end

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_ready(rr0), .resp_rdata(rd0),
    .resp_err(er0)
  );

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_ready(rr1), .resp_rdata(rd1),
    .resp_err(er1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int hold);
    exp_t e;
    int   j;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = ((sel != 0) ? 3 : 0) + 2;
    q.push_back(e);

    @(negedge clk);
    j = 0;
    while (!rdy && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk({tag, ".req_ready"}, 32'(rdy), 32'd1);
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    if (sel != 0) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
    j = 0;
    while (!rv && j < 50) begin
      chk({tag, ".busy"}, 32'(rdy), 32'd0);
      @(negedge clk);
      j++;
    end
    e = q.pop_front();
    chk({tag, ".latency"}, 32'(j + 1), 32'(e.lat));
    chk({tag, ".resp_valid"}, 32'(rv), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rv), 32'd1);
      chk({tag, ".hold_rdata"}, rd, e.rdata);
      chk({tag, ".hold_ready"}, 32'(rdy), 32'd0);
    end
    chk({tag, ".rdata"}, rd, e.rdata);
    chk({tag, ".err"}, 32'(er), 32'(e.err));
    if (sel != 0) rr1 = 1'b1; else rr0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr0 = 1'b0;
    rr1 = 1'b0;
    chk({tag, ".resp_drop"}, 32'(rv), 32'd0);
    chk({tag, ".ready_back"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    sel = 0;
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.ready0", 32'(rdy0), 32'd1);
    chk("rst.valid0", 32'(rv0), 32'd0);
    chk("rst.rdata0", rd0, 32'd0);
    chk("rst.err0", 32'(er0), 32'd0);
    chk("rst.ready1", 32'(rdy1), 32'd1);
    chk("rst.valid1", 32'(rv1), 32'd0);

    xact("sw10", 1, SZ_W, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    xact("lw10", 0, SZ_W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);

    xact("sw20", 1, SZ_W, 0, 32'h20, 32'h0, 32'h0, 0, 0);
    xact("sb23", 1, SZ_B, 0, 32'h23, 32'h80, 32'h0, 0, 0);
    xact("lw20", 0, SZ_W, 0, 32'h20, 32'h0, 32'h80000000, 0, 0);
    xact("lb23", 0, SZ_B, 0, 32'h23, 32'h0, 32'hFFFFFF80, 0, 0);
    xact("lbu23", 0, SZ_B, 1, 32'h23, 32'h0, 32'h00000080, 0, 0);
    xact("lb20", 0, SZ_B, 0, 32'h20, 32'h0, 32'h00000000, 0, 0);

    xact("sw30", 1, SZ_W, 0, 32'h30, 32'h11223344, 32'h0, 0, 0);
    xact("sh32", 1, SZ_H, 0, 32'h32, 32'h8001, 32'h0, 0, 0);
    xact("lw30", 0, SZ_W, 0, 32'h30, 32'h0, 32'h80013344, 0, 0);
    xact("lh32", 0, SZ_H, 0, 32'h32, 32'h0, 32'hFFFF8001, 0, 0);
    xact("lhu32", 0, SZ_H, 1, 32'h32, 32'h0, 32'h00008001, 0, 0);
    xact("lh30", 0, SZ_H, 0, 32'h30, 32'h0, 32'h00003344, 0, 0);

    xact("lw11", 0, SZ_W, 0, 32'h11, 32'h0, 32'h0, 1, 0);
    xact("sw04", 1, SZ_W, 0, 32'h04, 32'h12345678, 32'h0, 0, 0);
    xact("sh05", 1, SZ_H, 0, 32'h05, 32'hFFFF, 32'h0, 1, 0);
    xact("lw04", 0, SZ_W, 0, 32'h04, 32'h0, 32'h12345678, 0, 0);
    xact("sw_oob", 1, SZ_W, 0, 32'd256, 32'h5A5A5A5A, 32'h0, 1, 0);
    xact("sw_last", 1, SZ_W, 0, 32'd252, 32'hA5A50F0F, 32'h0, 0, 0);
    xact("lw_last", 0, SZ_W, 0, 32'd252, 32'h0, 32'hA5A50F0F, 0, 0);
    xact("lw_sz11", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 0);

    sel = 1;
    xact("w3.sw08", 1, SZ_W, 0, 32'h08, 32'hCAFEF00D, 32'h0, 0, 0);
    xact("w3.lw08", 0, SZ_W, 0, 32'h08, 32'h0, 32'hCAFEF00D, 0, 5);
    xact("w3.lw11", 0, SZ_W, 0, 32'h11, 32'h0, 32'h0, 1, 5);

    sel = 0;
    xact("sw40", 1, SZ_W, 0, 32'h40, 32'h55555555, 32'h0, 0, 0);
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hAAAAAAAA;
    v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    chk("rst_mid.in_access_ready", 32'(rdy0), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid.valid", 32'(rv0), 32'd0);
    chk("rst_mid.ready", 32'(rdy0), 32'd1);
    xact("rst_mid.lw40", 0, SZ_W, 0, 32'h40, 32'h0, 32'h55555555, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
